conv3x3_stream: RTL and testbench

- Streaming 3x3 valid-mode convolution stage that feeds pool_relu.
- Accepts a raster-scan 28x28 frame, one signed pixel per valid cycle.
- Emits the 26x26 signed 32-bit convolution result, one result per valid cycle, in raster order, in the exact stream format pool_relu consumes.
- Uses two line buffers plus a 3x3 window register; one MAC tree, no stalls.

---
 rtl/conv3x3_stream.sv | 126 ++++++++++++
 tb/tb_conv3x3_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution over a square raster frame.
// Two line buffers plus a 3x3 window feed one MAC tree; results are registered one cycle after the pixel.
module conv3x3_stream #(
  parameter int In_W  = 8,
  parameter int Out_W = 32,
  parameter int W_IN  = 28,
  parameter int K     = 3
) (
  input  logic                 iClk,
  input  logic                 iRsn,
  input  logic                 iInValid,
  input  logic [In_W-1:0]      iPixel,
  input  logic                 iWeightLoad,
  input  logic [K*K*In_W-1:0]  iWeight,
  input  logic [Out_W-1:0]     iBias,
  output logic                 oOutValid,
  output logic [Out_W-1:0]     oOutData,
  output logic                 oFrameDone
);

  localparam int NTAP = K * K;
  localparam int PW   = 2 * In_W;
  localparam int CW   = $clog2(W_IN);
  localparam logic [CW-1:0] LAST = CW'(W_IN - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  // Full-precision product, sign-extended to the accumulator width (sum wraps modulo 2^Out_W).
  function automatic logic signed [Out_W-1:0] mac_term(input logic signed [In_W-1:0] a,
                                                       input logic signed [In_W-1:0] b);
    logic signed [PW-1:0] ae, be, p;
    ae = {{In_W{a[In_W-1]}}, a};
    be = {{In_W{b[In_W-1]}}, b};
    p  = ae * be;
    return {{(Out_W-PW){p[PW-1]}}, p};
  endfunction

  logic [CW-1:0]           row_cnt, col_cnt;
  logic signed [In_W-1:0]  lb0 [W_IN];
  logic signed [In_W-1:0]  lb1 [W_IN];
  logic signed [In_W-1:0]  win [NTAP];
  logic signed [In_W-1:0]  win_nxt [NTAP];
  logic signed [In_W-1:0]  wgt [NTAP];
  logic signed [Out_W-1:0] bias;
  logic signed [In_W-1:0]  pix_p0;
  logic signed [Out_W-1:0] acc_p0;
  logic signed [Out_W-1:0] data_p1;
  logic                    vld_p1, done_p1;
  logic                    fire_p0, last_p0, wload_p0;

  assign pix_p0   = iPixel;
  assign fire_p0  = iInValid && (row_cnt >= TWO) && (col_cnt >= TWO);
  assign last_p0  = (row_cnt == LAST) && (col_cnt == LAST);
  assign wload_p0 = iWeightLoad && !iInValid && (row_cnt == '0) && (col_cnt == '0);

  // Stage p0: window after this pixel's shift, with the new right column read before the buffer write
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (j < K - 1)
          win_nxt[i*K+j] = win[i*K+j+1];
        else if (i == 0)
          win_nxt[i*K+j] = lb0[col_cnt];
        else if (i == 1)
          win_nxt[i*K+j] = lb1[col_cnt];
        else
          win_nxt[i*K+j] = pix_p0;
      end
    end
  end

  always_comb begin
    acc_p0 = bias;
    for (int t = 0; t < NTAP; t++)
      acc_p0 = acc_p0 + mac_term(win_nxt[t], wgt[t]);
  end

  // Stage p1: registered result, valid and frame-done
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      row_cnt <= '0;
      col_cnt <= '0;
      for (int c = 0; c < W_IN; c++) begin
        lb0[c] <= '0;
        lb1[c] <= '0;
      end
      for (int t = 0; t < NTAP; t++) begin
        win[t] <= '0;
        wgt[t] <= '0;
      end
      bias    <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (wload_p0) begin
        for (int t = 0; t < NTAP; t++)
          wgt[t] <= iWeight[In_W*t +: In_W];
        bias <= iBias;
      end
      if (iInValid) begin
        lb0[col_cnt] <= lb1[col_cnt];
        lb1[col_cnt] <= pix_p0;
        for (int t = 0; t < NTAP; t++)
          win[t] <= win_nxt[t];
        if (col_cnt == LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (fire_p0) begin
          vld_p1  <= 1'b1;
          done_p1 <= last_p0;
          data_p1 <= acc_p0;
        end
      end
    end
  end

  assign oOutValid  = vld_p1;
  assign oOutData   = data_p1;
  assign oFrameDone = done_p1;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised bench for conv3x3_stream: a frame-array reference model predicts every result and its cycle.
module tb_conv3x3_stream;

  logic        iClk;
  logic        iRsn;
  logic        iInValid;
  logic [7:0]  iPixel;
  logic        iWeightLoad;
  logic [71:0] iWeight;
  logic [31:0] iBias;
  logic        oOutValid;
  logic [31:0] oOutData;
  logic        oFrameDone;

  conv3x3_stream dut (
    .iClk(iClk), .iRsn(iRsn), .iInValid(iInValid), .iPixel(iPixel),
    .iWeightLoad(iWeightLoad), .iWeight(iWeight), .iBias(iBias),
    .oOutValid(oOutValid), .oOutData(oOutData), .oFrameDone(oFrameDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic signed [31:0] d;
    bit                 done;
    int                 cyc;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pos = 0;
  int   fr [28][28];
  int   mw [9];
  int   mb = 0;
  logic signed [31:0] hold_ref = 0;
  int   got_cnt = 0, done_cnt = 0;
  logic signed [31:0] first_data = 0, last_data = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: store the frame by (row, col) and apply the convolution formula directly.
  always @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      pos = 0;
      mb  = 0;
      for (int t = 0; t < 9; t++) mw[t] = 0;
      expq.delete();
    end else begin
      cyc++;
      if (iWeightLoad && !iInValid && pos == 0) begin
        for (int t = 0; t < 9; t++) mw[t] = $signed(iWeight[8*t +: 8]);
        mb = $signed(iBias);
      end
      if (iInValid) begin
        int r, c;
        r = pos / 28;
        c = pos % 28;
        fr[r][c] = $signed(iPixel);
        if (r >= 2 && c >= 2) begin
          longint acc;
          exp_t e;
          acc = mb;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += longint'(fr[r-2+i][c-2+j]) * mw[i*3+j];
          e.d    = 32'(acc);
          e.done = (pos == 783);
          e.cyc  = cyc;
          expq.push_back(e);
        end
        pos = (pos + 1) % 784;
      end
    end
  end

  always @(negedge iClk) begin
    if (!iRsn) begin
      hold_ref = 0;
    end else if (oOutValid) begin
      if (expq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("out_data", $signed(oOutData), e.d);
        chk("frame_done", oFrameDone, e.done);
        chk("out_latency_cycle", cyc, e.cyc);
      end
      if (got_cnt == 0) first_data = oOutData;
      last_data = oOutData;
      got_cnt++;
      if (oFrameDone) done_cnt++;
      hold_ref = oOutData;
    end else begin
      chk("data_hold", $signed(oOutData), hold_ref);
      chk("done_without_valid", oFrameDone, 0);
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_stats();
    got_cnt = 0;
    done_cnt = 0;
  endtask

  function automatic logic [71:0] kern_fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] kern_rand();
    logic [71:0] w;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[71:64] = 8'($urandom);
    return w;
  endfunction

  task automatic load_w(input logic [71:0] w, input logic [31:0] b);
    iWeight = w;
    iBias = b;
    iWeightLoad = 1'b1;
    tick();
    iWeightLoad = 1'b0;
  endtask

  // mode 0: (r*28+c) mod 128, 1: all 1, 2: all -128, 3: random
  task automatic run_frame(input int mode, input int gap, input int ld_idx,
                           input logic [71:0] lw, input logic [31:0] lb, input int rst_idx);
    for (int idx = 0; idx < 784; idx++) begin
      if (idx == rst_idx) begin
        #2 iRsn = 1'b0;
        #1;
        chk("midreset_valid", oOutValid, 0);
        chk("midreset_data", oOutData, 0);
        chk("midreset_done", oFrameDone, 0);
        tick();
        iRsn = 1'b1;
        tick();
        return;
      end
      while ($urandom_range(0, 99) < gap) tick();
      if (idx == ld_idx && idx != 0) load_w(lw, lb);
      case (mode)
        0:       iPixel = 8'(idx % 128);
        1:       iPixel = 8'd1;
        2:       iPixel = 8'h80;
        default: iPixel = 8'($urandom);
      endcase
      if (idx == ld_idx && idx == 0) begin
        iWeight = lw;
        iBias = lb;
        iWeightLoad = 1'b1;
      end
      iInValid = 1'b1;
      tick();
      iInValid = 1'b0;
      iWeightLoad = 1'b0;
    end
  endtask

  initial begin
    iRsn = 1'b0;
    iInValid = 1'b0;
    iPixel = '0;
    iWeightLoad = 1'b0;
    iWeight = '0;
    iBias = '0;
    #12;
    chk("reset_valid", oOutValid, 0);
    chk("reset_data", oOutData, 0);
    chk("reset_done", oFrameDone, 0);
    tick();
    iRsn = 1'b1;
    tick();

    // Identity kernel, two back-to-back frames
    load_w(72'd1 << 32, 32'd0);
    clear_stats();
    run_frame(0, 0, -1, '0, '0, -1);
    run_frame(0, 0, -1, '0, '0, -1);
    repeat (3) tick();
    chk("identity_first", first_data, 29);
    chk("identity_last", last_data, 114);
    chk("identity_count", got_cnt, 1352);
    chk("identity_done_count", done_cnt, 2);

    // All ones, bias 5
    load_w(kern_fill(8'd1), 32'd5);
    clear_stats();
    run_frame(1, 0, -1, '0, '0, -1);
    repeat (3) tick();
    chk("ones_first", first_data, 14);
    chk("ones_last", last_data, 14);
    chk("ones_count", got_cnt, 676);

    // Extreme negative operands
    load_w(kern_fill(8'h80), 32'hFFFF_FFFF);
    clear_stats();
    run_frame(2, 0, -1, '0, '0, -1);
    repeat (3) tick();
    chk("neg_first", first_data, 147455);
    chk("neg_last", last_data, 147455);

    // Random data, kernel and gaps
    for (int f = 0; f < 2; f++) begin
      load_w(kern_rand(), 32'($urandom_range(0, 2000)) - 32'd1000);
      clear_stats();
      run_frame(3, 40, -1, '0, '0, -1);
      repeat (3) tick();
      chk("rand_count", got_cnt, 676);
      chk("rand_done_count", done_cnt, 1);
    end

    // Reset in the middle of row 10, then reload and run a full frame
    load_w(kern_rand(), 32'd77);
    run_frame(3, 40, -1, '0, '0, 10 * 28 + 5);
    load_w(kern_rand(), 32'($urandom_range(0, 500)));
    clear_stats();
    run_frame(3, 40, -1, '0, '0, -1);
    repeat (3) tick();
    chk("post_reset_count", got_cnt, 676);
    chk("post_reset_done_count", done_cnt, 1);

    // Loads during a frame and with a valid pixel are ignored; an idle load takes effect
    load_w(72'd1 << 32, 32'd0);
    clear_stats();
    run_frame(0, 20, 300, kern_fill(8'd1), 32'd5, -1);
    run_frame(0, 0, 0, kern_fill(8'd1), 32'd5, -1);
    repeat (3) tick();
    chk("ignored_load_first", first_data, 29);
    chk("ignored_load_last", last_data, 114);
    load_w(kern_fill(8'd1), 32'd5);
    clear_stats();
    run_frame(1, 0, -1, '0, '0, -1);
    repeat (3) tick();
    chk("idle_load_first", first_data, 14);
    chk("idle_load_count", got_cnt, 676);

    repeat (4) tick();
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
